// File: rtl/calendar_pkg.sv
// Calendar field widths, limits, reset defaults and month-length helper.
// Optional build macro: CENTURY_LEAP_EN (February gets 29 days when year[1:0]==0).
package calendar_pkg;

    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned DAY_W   = 5;
    localparam int unsigned MONTH_W = 4;
    localparam int unsigned YEAR_W  = 7;
    localparam int unsigned STEP_W  = 7;

    localparam int unsigned SEC_MAX   = 59;
    localparam int unsigned MIN_MAX   = 59;
    localparam int unsigned HOUR_MAX  = 23;
    localparam int unsigned MONTH_MAX = 12;
    localparam int unsigned YEAR_MAX  = 99;

    localparam int unsigned RST_YEAR  = 0;
    localparam int unsigned RST_MONTH = 1;
    localparam int unsigned RST_DAY   = 1;

    // Bit positions of the adjust requests inside the packed request vector.
    localparam int unsigned ADJ_N       = 12;
    localparam int unsigned ADJ_UP_S    = 0;
    localparam int unsigned ADJ_DN_S    = 1;
    localparam int unsigned ADJ_UP_M    = 2;
    localparam int unsigned ADJ_DN_M    = 3;
    localparam int unsigned ADJ_UP_H    = 4;
    localparam int unsigned ADJ_DN_H    = 5;
    localparam int unsigned ADJ_UP_D    = 6;
    localparam int unsigned ADJ_DN_D    = 7;
    localparam int unsigned ADJ_UP_MO   = 8;
    localparam int unsigned ADJ_DN_MO   = 9;
    localparam int unsigned ADJ_UP_Y    = 10;
    localparam int unsigned ADJ_DN_Y    = 11;

    // Complete timekeeping state.
    typedef struct packed {
        logic [YEAR_W-1:0]  year;
        logic [MONTH_W-1:0] month;
        logic [DAY_W-1:0]   day;
        logic [HOUR_W-1:0]  hour;
        logic [MIN_W-1:0]   min;
        logic [SEC_W-1:0]   sec;
    } cal_time_t;

    // Length of a month; the leap term exists only in the leap-enabled build.
    function automatic logic [DAY_W-1:0] days_in_month(
        input logic [MONTH_W-1:0] month,
        input logic [YEAR_W-1:0]  year
    );
        logic [DAY_W-1:0] d;
        case (month)
            MONTH_W'(2): begin
`ifdef CENTURY_LEAP_EN
                d = (year[1:0] == 2'b00) ? DAY_W'(29) : DAY_W'(28);
`else
                d = DAY_W'(28);
`endif
            end
            MONTH_W'(4), MONTH_W'(6), MONTH_W'(9), MONTH_W'(11): d = DAY_W'(30);
            default: d = DAY_W'(31);
        endcase
        return d;
    endfunction

    // Single-field up/down step with wrap inside [lo, hi]; both strobes cancel.
    function automatic logic [STEP_W-1:0] step_field(
        input logic [STEP_W-1:0] v,
        input logic [STEP_W-1:0] lo,
        input logic [STEP_W-1:0] hi,
        input logic              up,
        input logic              dn
    );
        logic [STEP_W-1:0] r;
        r = v;
        if (up && !dn) begin
            r = (v >= hi) ? lo : v + STEP_W'(1);
        end else if (dn && !up) begin
            r = (v <= lo) ? hi : v - STEP_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: history flop plus AND-NOT, history cleared on reset.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic pulse_c_o
);

    logic hist_q;

    // Track the previous level every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= level_i;
        end
    end

    assign pulse_c_o = level_i & ~hist_q;

endmodule

// File: rtl/calendar_counter.sv
// Century clock timekeeping datapath: 1 Hz cascade in run mode, per-field
// adjust in set mode. Optional build macro: CENTURY_LEAP_EN.
module calendar_counter
    import calendar_pkg::*;
#(
    parameter int unsigned RESET_YEAR  = RST_YEAR,
    parameter int unsigned RESET_MONTH = RST_MONTH,
    parameter int unsigned RESET_DAY   = RST_DAY
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_1hz,
    input  logic               run,
    input  logic               up_s,
    input  logic               down_s,
    input  logic               up_m,
    input  logic               down_m,
    input  logic               up_h,
    input  logic               down_h,
    input  logic               up_d,
    input  logic               down_d,
    input  logic               up_mo,
    input  logic               down_mo,
    input  logic               up_y,
    input  logic               down_y,
    output logic [SEC_W-1:0]   sec,
    output logic [MIN_W-1:0]   min,
    output logic [HOUR_W-1:0]  hour,
    output logic [DAY_W-1:0]   day,
    output logic [MONTH_W-1:0] month,
    output logic [YEAR_W-1:0]  year,
    output logic               century_wrap
);

    logic [ADJ_N-1:0] adj_lvl;
    logic [ADJ_N-1:0] adj_pulse;
    cal_time_t        t_q, t_d;
    logic             wrap_q, wrap_d;
    logic [DAY_W-1:0] dim_cur;
    logic [DAY_W-1:0] dim_new;

    assign adj_lvl = {down_y, up_y, down_mo, up_mo, down_d, up_d,
                      down_h, up_h, down_m, up_m, down_s, up_s};

    // One edge detector per adjust request; history runs regardless of mode.
    for (genvar g = 0; g < ADJ_N; g++) begin : g_rise
        rise_detect u_rise (
            .clk       (clk),
            .rst_n     (rst_n),
            .level_i   (adj_lvl[g]),
            .pulse_c_o (adj_pulse[g])
        );
    end

    // Next-state: full single-cycle carry on tick, or independent field steps.
    always_comb begin
        t_d     = t_q;
        wrap_d  = 1'b0;
        dim_cur = days_in_month(t_q.month, t_q.year);
        dim_new = dim_cur;

        if (run) begin
            if (tick_1hz) begin
                if (t_q.sec == SEC_W'(SEC_MAX)) begin
                    t_d.sec = '0;
                    if (t_q.min == MIN_W'(MIN_MAX)) begin
                        t_d.min = '0;
                        if (t_q.hour == HOUR_W'(HOUR_MAX)) begin
                            t_d.hour = '0;
                            if (t_q.day >= dim_cur) begin
                                t_d.day = DAY_W'(1);
                                if (t_q.month == MONTH_W'(MONTH_MAX)) begin
                                    t_d.month = MONTH_W'(1);
                                    if (t_q.year == YEAR_W'(YEAR_MAX)) begin
                                        t_d.year = '0;
                                        wrap_d   = 1'b1;
                                    end else begin
                                        t_d.year = t_q.year + YEAR_W'(1);
                                    end
                                end else begin
                                    t_d.month = t_q.month + MONTH_W'(1);
                                end
                            end else begin
                                t_d.day = t_q.day + DAY_W'(1);
                            end
                        end else begin
                            t_d.hour = t_q.hour + HOUR_W'(1);
                        end
                    end else begin
                        t_d.min = t_q.min + MIN_W'(1);
                    end
                end else begin
                    t_d.sec = t_q.sec + SEC_W'(1);
                end
            end
        end else begin
            t_d.sec   = SEC_W'(step_field(STEP_W'(t_q.sec), '0, STEP_W'(SEC_MAX),
                                          adj_pulse[ADJ_UP_S], adj_pulse[ADJ_DN_S]));
            t_d.min   = MIN_W'(step_field(STEP_W'(t_q.min), '0, STEP_W'(MIN_MAX),
                                          adj_pulse[ADJ_UP_M], adj_pulse[ADJ_DN_M]));
            t_d.hour  = HOUR_W'(step_field(STEP_W'(t_q.hour), '0, STEP_W'(HOUR_MAX),
                                           adj_pulse[ADJ_UP_H], adj_pulse[ADJ_DN_H]));
            t_d.month = MONTH_W'(step_field(STEP_W'(t_q.month), STEP_W'(1), STEP_W'(MONTH_MAX),
                                            adj_pulse[ADJ_UP_MO], adj_pulse[ADJ_DN_MO]));
            t_d.year  = YEAR_W'(step_field(STEP_W'(t_q.year), '0, STEP_W'(YEAR_MAX),
                                           adj_pulse[ADJ_UP_Y], adj_pulse[ADJ_DN_Y]));
            // Day wraps against the current month, then clamps to the new one.
            t_d.day   = DAY_W'(step_field(STEP_W'(t_q.day), STEP_W'(1), STEP_W'(dim_cur),
                                          adj_pulse[ADJ_UP_D], adj_pulse[ADJ_DN_D]));
            dim_new   = days_in_month(t_d.month, t_d.year);
            if (t_d.day > dim_new) begin
                t_d.day = dim_new;
            end
        end
    end

    // Field and wrap-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q.sec   <= '0;
            t_q.min   <= '0;
            t_q.hour  <= '0;
            t_q.day   <= DAY_W'(RESET_DAY);
            t_q.month <= MONTH_W'(RESET_MONTH);
            t_q.year  <= YEAR_W'(RESET_YEAR);
            wrap_q    <= 1'b0;
        end else begin
            t_q       <= t_d;
            wrap_q    <= wrap_d;
        end
    end

    assign sec          = t_q.sec;
    assign min          = t_q.min;
    assign hour         = t_q.hour;
    assign day          = t_q.day;
    assign month        = t_q.month;
    assign year         = t_q.year;
    assign century_wrap = wrap_q;

endmodule

// File: tb/tb_calendar_counter.sv
// Directed bench for calendar_counter; expected values are hand-computed.
// Expectations follow the CENTURY_LEAP_EN setting of the build.
module tb_calendar_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_1hz;
    logic        run;
    logic [11:0] adj;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [6:0]  year;
    logic        century_wrap;

    int n_cmp = 0;
    int n_err = 0;
    int wraps;

    localparam int UP_S = 0, DN_S = 1, UP_M = 2, DN_M = 3, UP_H = 4, DN_H = 5;
    localparam int UP_D = 6, DN_D = 7, UP_MO = 8, DN_MO = 9, UP_Y = 10, DN_Y = 11;

    always #5 clk = ~clk;

    calendar_counter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1hz     (tick_1hz),
        .run          (run),
        .up_s         (adj[UP_S]),
        .down_s       (adj[DN_S]),
        .up_m         (adj[UP_M]),
        .down_m       (adj[DN_M]),
        .up_h         (adj[UP_H]),
        .down_h       (adj[DN_H]),
        .up_d         (adj[UP_D]),
        .down_d       (adj[DN_D]),
        .up_mo        (adj[UP_MO]),
        .down_mo      (adj[DN_MO]),
        .up_y         (adj[UP_Y]),
        .down_y       (adj[DN_Y]),
        .sec          (sec),
        .min          (min),
        .hour         (hour),
        .day          (day),
        .month        (month),
        .year         (year),
        .century_wrap (century_wrap)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int y, input int mo, input int d,
                              input int h, input int mi, input int s);
        check({tag, ".year"},  int'(year),  y);
        check({tag, ".month"}, int'(month), mo);
        check({tag, ".day"},   int'(day),   d);
        check({tag, ".hour"},  int'(hour),  h);
        check({tag, ".min"},   int'(min),   mi);
        check({tag, ".sec"},   int'(sec),   s);
    endtask

    task automatic do_reset(input logic run_mode);
        @(negedge clk);
        rst_n    = 1'b0;
        adj      = '0;
        tick_1hz = 1'b0;
        run      = run_mode;
        @(negedge clk);
        rst_n    = 1'b1;
        @(negedge clk);
    endtask

    // One clean rising edge per press on the selected adjust input.
    task automatic press(input int idx, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            adj[idx] = 1'b1;
            @(negedge clk);
            adj[idx] = 1'b0;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        run      = 1'b1;
        adj      = '0;
        repeat (2) @(negedge clk);
        check_time("reset", 0, 1, 1, 0, 0, 0);
        check("reset.wrap", int'(century_wrap), 0);
        rst_n = 1'b1;

        // One full day of ticks from reset.
        @(negedge clk);
        wraps    = 0;
        tick_1hz = 1'b1;
        for (int i = 0; i < 86400; i++) begin
            @(negedge clk);
            if (century_wrap) wraps++;
        end
        tick_1hz = 1'b0;
        check_time("day", 0, 1, 2, 0, 0, 0);
        check("day.wraps", wraps, 0);

        // Preload 2099-12-31 23:59:59 then one tick across the century.
        do_reset(1'b0);
        press(DN_S, 1);
        press(DN_M, 1);
        press(DN_H, 1);
        press(DN_MO, 1);
        press(DN_D, 1);
        press(DN_Y, 1);
        check_time("preload", 99, 12, 31, 23, 59, 59);
        @(negedge clk);
        run      = 1'b1;
        tick_1hz = 1'b1;
        @(posedge clk);
        #1;
        check_time("century", 0, 1, 1, 0, 0, 0);
        check("century.wrap", int'(century_wrap), 1);
        @(negedge clk);
        tick_1hz = 1'b0;
        @(posedge clk);
        #1;
        check("century.wrap_off", int'(century_wrap), 0);

        // Month/year change clamps the day.
        do_reset(1'b0);
        press(DN_D, 1);
        press(UP_Y, 4);
        check_time("jan31", 4, 1, 31, 0, 0, 0);
        press(UP_MO, 1);
`ifdef CENTURY_LEAP_EN
        check("clamp_mo.day", int'(day), 29);
`else
        check("clamp_mo.day", int'(day), 28);
`endif
        check("clamp_mo.month", int'(month), 2);
        press(UP_Y, 1);
        check("clamp_y.year", int'(year), 5);
        check("clamp_y.day", int'(day), 28);

        // Seconds borrow stays local; a held level steps once.
        do_reset(1'b0);
        press(DN_S, 1);
        check("down_s.sec", int'(sec), 59);
        check("down_s.min", int'(min), 0);
        @(negedge clk);
        adj[UP_S] = 1'b1;
        repeat (10) @(negedge clk);
        adj[UP_S] = 1'b0;
        @(negedge clk);
        check("hold_up_s.sec", int'(sec), 0);
        check("hold_up_s.min", int'(min), 0);

        // Opposing strobes cancel; ticks ignored in set mode.
        press(UP_H, 2);
        @(negedge clk);
        adj[UP_H] = 1'b1;
        adj[DN_H] = 1'b1;
        @(negedge clk);
        adj[UP_H] = 1'b0;
        adj[DN_H] = 1'b0;
        check("updown_h.hour", int'(hour), 2);
        tick_1hz = 1'b1;
        repeat (3) @(negedge clk);
        tick_1hz = 1'b0;
        check("set_tick.sec", int'(sec), 0);

        // Asynchronous reset right after a day cascade.
        do_reset(1'b0);
        press(DN_S, 1);
        press(DN_M, 1);
        press(DN_H, 1);
        @(negedge clk);
        run      = 1'b1;
        tick_1hz = 1'b1;
        @(posedge clk);
        #1;
        check_time("cascade", 0, 1, 2, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_time("async_rst", 0, 1, 1, 0, 0, 0);
        check("async_rst.wrap", int'(century_wrap), 0);
        @(posedge clk);
        #1;
        check_time("held_rst", 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        tick_1hz = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/calendar_counter.md
# calendar_counter

Timekeeping datapath of the century clock: holds seconds, minutes, hours, day, month and year (2000–2099), advances them on a 1 Hz tick in run mode, and applies the per-field up/down adjust strobes from the control unit in set mode. Sits directly downstream of the control unit. Its registered field outputs feed the display/blink stage.

## Interface
- RESET_YEAR, 0, year offset (0..99, i.e. 2000+RESET_YEAR) loaded on reset
- RESET_MONTH, 1, month (1..12) loaded on reset
- RESET_DAY, 1, day (1..28) loaded on reset
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tick_1hz  in  1  one-cycle pulse, once per second
- run  in  1  1 = timekeeping, 0 = set mode (driven by the same enable as the control unit's en)
- up_s, down_s, up_m, down_m, up_h, down_h  in  1 each  level adjust requests: seconds, minutes, hours
- up_d, down_d, up_mo, down_mo, up_y, down_y  in  1 each  level adjust requests: day, month, year
- sec  out  6  0..59
- min  out  6  0..59
- hour  out  5  0..23
- day  out  5  1..days_in_month
- month  out  4  1..12
- year  out  7  0..99 (offset from 2000)
- century_wrap  out  1  one-cycle pulse when run-mode carry takes year 99→0

## Operation
- Reset values:
  - sec=0, min=0, hour=0.
  - day=RESET_DAY, month=RESET_MONTH, year=RESET_YEAR.
  - century_wrap=0.
  - All 12 edge-detect history registers =0.
- Edge detection: each adjust input is registered every cycle regardless of run. Its step pulse = input & ~history. A level held across reset release therefore yields exactly one step.
- Run mode (run=1):
  - On tick_1hz, increment sec with a full cascade: sec 59→0 carries min, min 59→0 carries hour, hour 23→0 carries day.
  - day equal to days_in_month(month,year) wraps to 1 and carries month.
  - month 12→1 carries year.
  - year 99→0 with century_wrap=1.
  - All adjust pulses are ignored.
- Set mode (run=0):
  - tick_1hz is ignored; time is frozen.
  - Each up pulse increments only its field; each down pulse decrements only its field. No carry or borrow into other fields.
  - Wrap ranges: sec/min 0..59, hour 0..23, month 1..12, year 0..99, day 1..days_in_month(current month, year).
- Day clamping after a month or year change: if day > days_in_month(new month, new year), day becomes that maximum in the same update. Examples: Jan 31 + up_mo → Feb 29 (leap) or Feb 28; Feb 29 year 4 + up_y → Feb 28 year 5.
- Simultaneous up and down pulses on the same field in the same cycle produce no change. Pulses on different fields in the same cycle are all applied; clamping uses the post-update month and year.
- Leap year: year[1:0]==0. This is exact for 2000–2099.
- run toggling mid-press: history keeps tracking, so an edge that occurred while run=1 is not replayed when run falls.

## Timing
- All outputs are registered.
- A tick sampled at cycle N makes the whole cascade, including century_wrap, visible at N+1. Single-cycle combinational carry.
- An adjust rising edge at cycle N (input=1, history=0) updates the field at N+1. A held level gives no further steps.
- century_wrap is high for exactly one cycle.
- Asynchronous reset takes effect immediately mid-operation. No partial cascade survives it.

## Configuration
- CENTURY_LEAP_EN defined: February has 29 days when year[1:0]==0, 28 otherwise.
- CENTURY_LEAP_EN undefined: February always has 28 days. Leap logic is removed, and clamping and run-mode rollover use 28.

## Structure
- Package calendar_pkg holds:
  - Field width constants and limits (SEC_MAX=59, HOUR_MAX=23, MONTH_MAX=12, YEAR_MAX=99).
  - Reset defaults.
  - Function days_in_month(month, year), with the leap term under CENTURY_LEAP_EN.
- Sub-module rise_detect (history flop plus AND-NOT, reset 0), instantiated 12 times.
- Field counters stay inline in calendar_counter.

## Test plan
- Reset, run=1, pulse tick_1hz 86400 times → Jan 2 00:00:00 (year=0, month=1, day=2), with no century_wrap.
- Preload Dec 31 year 99 23:59:59 via set mode, then run=1 and one tick → 2000-01-01 00:00:00 and century_wrap=1 for one cycle.
- Set mode, day=31 month=1 year=4, up_mo rising → month=2 day=29. Then up_y rising → year=5 day=28. Without CENTURY_LEAP_EN the first step already gives day=28.
- Set mode, sec=0, down_s rising → sec=59 with min unchanged. Hold up_s high 10 cycles → sec increments exactly once.
- Set mode, up_h and down_h rise in the same cycle → hour unchanged. Tick pulses while run=0 → sec unchanged.
- Assert rst_n=0 mid-cascade (tick at 23:59:59) → all fields return to reset values immediately and century_wrap=0.
